// File: rtl/memory_access_pipeline_if.sv
// ---------------------------------------------------------------------------
// memory_access_pipeline_if
//   Data-memory request bus between the MA stage (master) and data memory
//   (slave).
//
//   Handshake: the master raises mem_req and holds it, together with
//   mem_we / mem_addr / mem_wdata, stable until the slave returns a
//   one-cycle mem_ack pulse. mem_rdata is meaningful only in the mem_ack
//   cycle. The request is dropped in the cycle after the ack, and also in
//   the cycle after a timeout or reset abort.
//
//   Signals:
//     mem_req    master->slave  1   request pending
//     mem_we     master->slave  1   1 = store, 0 = load
//     mem_addr   master->slave  32  word-aligned byte address
//     mem_wdata  master->slave  32  store data
//     mem_rdata  slave->master  32  load data, valid with mem_ack
//     mem_ack    slave->master  1   one-cycle completion pulse
// ---------------------------------------------------------------------------
interface memory_access_pipeline_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_access_pipeline.sv
// ---------------------------------------------------------------------------
// memory_access_pipeline
//   MA stage of the SimpleRisc pipeline. It sits directly behind the EX->MA
//   latch. Non-memory instructions pass into the MA->RW latch in one cycle.
//   Loads and stores are parked in holding registers and issued on the
//   data-memory bus. Upstream stays frozen (stall) until the access
//   completes or times out.
//
//   Optional feature macro: MEM_MISALIGN_TRAP_EN
//     When defined, a load or store whose aluResult[1:0] != 0 is not issued.
//     It completes on the next edge with bus_err=1 and control_out=0.
//     When undefined, the low address bits are dropped and a word access
//     is made at the aligned address.
//
//   Ports:
//     clk, rst           clock; synchronous active-high reset
//     in_valid           EX->MA latch holds a valid instruction
//     pc, aluResult,     instruction fields; aluResult is the byte address
//     op2, instruction,  for loads and stores, and op2 is the store data
//     control
//     stall              freeze EX->MA latch and upstream (combinational)
//     mem                data-memory bus (master modport)
//     out_valid ..       registered MA->RW latch contents
//     bus_err            registered; 1 only with an aborted or trapped op
//     dbg_state_o        current FSM state (0 = IDLE, 1 = WAIT)
// ---------------------------------------------------------------------------
module memory_access_pipeline #(
  parameter int CTRL_LD_BIT = 13,
  parameter int CTRL_ST_BIT = 14,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [31:0]                     pc,
  input  logic [31:0]                     aluResult,
  input  logic [31:0]                     op2,
  input  logic [31:0]                     instruction,
  input  logic [23:0]                     control,
  output logic                            stall,
  memory_access_pipeline_if.master        mem,
  output logic                            out_valid,
  output logic [31:0]                     pc_out,
  output logic [31:0]                     aluResult_out,
  output logic [31:0]                     instruction_out,
  output logic [31:0]                     ldResult_out,
  output logic [23:0]                     control_out,
  output logic                            bus_err,
  output logic                            dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   tmo_cnt_q;

  // Holding registers for the in-flight memory op
  logic [31:0]     hold_pc_q;
  logic [31:0]     hold_alu_q;
  logic [31:0]     hold_wdata_q;
  logic [31:0]     hold_instr_q;
  logic [23:0]     hold_ctrl_q;
  logic            hold_ld_q;
  logic            hold_we_q;

  logic            is_st;
  logic            is_ld;
  logic            memop;
  logic            misalign;
  logic            timeout_hit;
  logic            wait_done;

  // Both ld and st set is resolved as a store
  assign is_st = control[CTRL_ST_BIT];
  assign is_ld = control[CTRL_LD_BIT] & ~is_st;
  assign memop = in_valid & (control[CTRL_LD_BIT] | control[CTRL_ST_BIT]);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = memop & (aluResult[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign timeout_hit = (state_q == WAIT) && (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
  assign wait_done   = mem.mem_ack | timeout_hit;

  // Stall releases in the completing cycle so upstream advances on the same
  // edge that fills MA->RW. The next instruction is then seen in IDLE.
  always_comb begin
    stall = 1'b0;
    if (state_q == IDLE) stall = memop & ~misalign;
    else                 stall = ~wait_done;
  end

  assign mem.mem_req   = (state_q == WAIT);
  assign mem.mem_we    = hold_we_q;
  assign mem.mem_addr  = {hold_alu_q[31:2], 2'b00};
  assign mem.mem_wdata = hold_wdata_q;
  assign dbg_state_o   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      tmo_cnt_q       <= '0;
      hold_pc_q       <= '0;
      hold_alu_q      <= '0;
      hold_wdata_q    <= '0;
      hold_instr_q    <= '0;
      hold_ctrl_q     <= '0;
      hold_ld_q       <= 1'b0;
      hold_we_q       <= 1'b0;
      out_valid       <= 1'b0;
      pc_out          <= '0;
      aluResult_out   <= '0;
      instruction_out <= '0;
      ldResult_out    <= '0;
      control_out     <= '0;
      bus_err         <= 1'b0;
    end else begin
      // bus_err is a single-cycle flag that accompanies its out_valid
      bus_err <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_cnt_q <= '0;
          if (!in_valid) begin
            out_valid   <= 1'b0;
            control_out <= '0;
          end else if (misalign) begin
            // Trapped access: retire immediately with the ld/st suppressed
            out_valid       <= 1'b1;
            pc_out          <= pc;
            aluResult_out   <= aluResult;
            instruction_out <= instruction;
            ldResult_out    <= '0;
            control_out     <= '0;
            bus_err         <= 1'b1;
          end else if (memop) begin
            hold_pc_q    <= pc;
            hold_alu_q   <= aluResult;
            hold_wdata_q <= op2;
            hold_instr_q <= instruction;
            hold_ctrl_q  <= control;
            hold_ld_q    <= is_ld;
            hold_we_q    <= is_st;
            out_valid    <= 1'b0;
            control_out  <= '0;
            state_q      <= WAIT;
          end else begin
            out_valid       <= 1'b1;
            pc_out          <= pc;
            aluResult_out   <= aluResult;
            instruction_out <= instruction;
            ldResult_out    <= '0;
            control_out     <= control;
          end
        end

        WAIT: begin
          if (wait_done) begin
            // Ack beats a same-cycle timeout
            out_valid       <= 1'b1;
            pc_out          <= hold_pc_q;
            aluResult_out   <= hold_alu_q;
            instruction_out <= hold_instr_q;
            control_out     <= hold_ctrl_q;
            ldResult_out    <= (mem.mem_ack && hold_ld_q) ? mem.mem_rdata : 32'h0;
            bus_err         <= ~mem.mem_ack;
            tmo_cnt_q       <= '0;
            state_q         <= IDLE;
          end else begin
            out_valid   <= 1'b0;
            control_out <= '0;
            tmo_cnt_q   <= tmo_cnt_q + CW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
